zeroriscy_trace_unpacker: RTL and testbench
===========================================

Name: zeroriscy_trace_unpacker

Overview:
Receive side of the core's compact retirement-trace byte stream. Consumes serialized trace packets (instruction records, writeback-only records, sync markers) from the debug/trace link. Rebuilds full per-instruction records (cycle, pc, instr, rd write, memory address) for an on-chip trace buffer or host bridge. Sits between the trace-link byte FIFO and the trace record sink.

Parameters:
REG_ADDR_WIDTH, 5, width of register address field in records
TIMEOUT_CYCLES, 1024, max idle cycles between bytes inside a packet before abort; 0 disables

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  byte available
in_data  in  8  stream byte
in_ready  out  1  byte accepted when in_valid&&in_ready
rec_valid  out  1  record held on outputs
rec_ready  in  1  sink accepts record
rec_is_wb  out  1  1 = writeback-only record (no pc/instr)
rec_cycle  out  32  absolute cycle of record
rec_pc  out  32  instruction address
rec_instr  out  32  instruction word, upper 16 zero if compressed
rec_compressed  out  1  16-bit instruction
rec_rd_en  out  1  rd field valid
rec_rd_addr  out  REG_ADDR_WIDTH  destination register
rec_rd_value  out  32  destination value
rec_mem_en  out  1  memory address valid
rec_mem_addr  out  32  load/store physical address
err  out  1  one-cycle pulse on protocol error
in_sync  out  1  1 when locked to stream

Behaviour:
- Reset: all rec_* outputs 0, rec_valid 0, err 0, in_sync 0, cycle accumulator 0, FSM HUNT. Reset mid-packet discards partial record and any held record.
- Multi-byte fields little-endian. Header: [7:6] type (00 idle, 01 instr, 10 wb, 11 sync); instr: [0] has_rd, [1] has_mem, [2] compressed, [5:3] must be 0; wb and sync headers must be exactly 0x80 / 0xC0; idle must be 0x00.
- Instr packet: hdr, delta(1), pc(4), instr(2 if compressed else 4), [rd_addr(1), rd_value(4)] if has_rd, [mem_addr(4)] if has_mem. Wb packet: hdr, delta(1), rd_addr(1), rd_value(4). Sync: hdr, cycle(4).
- rd_addr byte bits [7:REG_ADDR_WIDTH] must be 0; violation = error.
- States: HUNT, HDR, DELTA, PC, INSTR, RDA, RDV, MEM, SYNC; 2-bit byte index within multi-byte fields.
- HUNT: every byte other than 0xC0 silently dropped; 0xC0 -> SYNC. SYNC completion loads accumulator, sets in_sync=1, -> HDR, emits no record.
- HDR: idle byte consumed, stays HDR. Sync header accepted while locked (resync).
- Cycle: on DELTA byte accumulator <= accumulator + delta, mod 2^32; rec_cycle carries updated value.
- Record completes on its last byte; registered into output one cycle after acceptance, rec_valid rises next cycle. Throughput: 1 byte/cycle, zero bubbles between packets.
- in_ready = 1 except when the current byte is a record's final byte and rec_valid && !rec_ready. Outputs stable while rec_valid && !rec_ready. rec_valid drops after handshake unless new record loads same cycle (back-to-back allowed).
- Simultaneous handshake-out and final-byte-in: new record replaces old, rec_valid stays 1.
- Error (bad header, reserved bits, bad rd_addr, timeout mid-packet): err pulses 1 cycle, partial packet discarded, in_sync=0, -> HUNT. Held record unaffected.
- Timeout counter resets on each accepted byte; counts only in states other than HUNT/HDR; expires at TIMEOUT_CYCLES consecutive idle cycles.

Decomposition:
- Package zeroriscy_trace_pkg: header type enum, flag bit positions, SYNC_HDR=8'hC0, WB_HDR=8'h80, IDLE=8'h00, trace_rec_t struct shared with the future encoder.
- Sub-module zeroriscy_trace_timeout: parameterized idle counter with clear/enable, expire pulse.

Test Plan:
- Bytes 11 22 C0 10 00 00 00 -> nothing emitted, no err, in_sync=1, accumulator 0x10.
- After sync 0x10: 43 05 00 01 00 80 13 05 A0 00 0A 2A 00 00 00 00 20 00 80 -> rec cycle 0x15, pc 0x80000100, instr 0x00A00513, rd x10=0x2A, mem 0x80002000.
- After sync: 44 03 04 02 00 80 05 45 -> compressed, instr 0x00004505, rd_en=0, mem_en=0, cycle +3.
- rec_ready held 0 while two instr packets arrive -> in_ready low on second packet's last byte until first handshake; both records delivered in order, outputs unchanged while stalled.
- Header 0x48 mid-stream -> err 1 cycle, in_sync=0, subsequent 80 01 05 ... dropped until 0xC0.
- Partial packet then TIMEOUT_CYCLES idle cycles -> err pulse exactly at expiry, HUNT; accumulator FFFFFFFF + delta 02 after resync wraps to 00000001.

Source files
------------

// File: rtl/zeroriscy_trace_pkg.sv
// Shared definitions for the zeroriscy compact retirement-trace format,
// used by the receive-side unpacker and the future encoder.
package zeroriscy_trace_pkg;

  typedef enum logic [1:0] {
    HDR_IDLE  = 2'b00,
    HDR_INSTR = 2'b01,
    HDR_WB    = 2'b10,
    HDR_SYNC  = 2'b11
  } hdr_type_e;

  localparam int FLAG_HAS_RD     = 0;
  localparam int FLAG_HAS_MEM    = 1;
  localparam int FLAG_COMPRESSED = 2;

  localparam logic [7:0] SYNC_HDR = 8'hC0;
  localparam logic [7:0] WB_HDR   = 8'h80;
  localparam logic [7:0] IDLE     = 8'h00;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_HDR,
    ST_DELTA,
    ST_PC,
    ST_INSTR,
    ST_RDA,
    ST_RDV,
    ST_MEM,
    ST_SYNC
  } unpack_state_e;

  // Register address travels beside this struct because its width is per-instance.
  typedef struct packed {
    logic        is_wb;
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        compressed;
    logic        rd_en;
    logic [31:0] rd_value;
    logic        mem_en;
    logic [31:0] mem_addr;
  } trace_rec_t;

  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    res[8*idx +: 8] = b;
    return res;
  endfunction

  function automatic logic instr_hdr_ok(input logic [7:0] h);
    return (h[7:6] == HDR_INSTR) && (h[5:3] == 3'b000);
  endfunction

endpackage

// File: rtl/zeroriscy_trace_timeout.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and pulses
// o_expire on the CYCLES-th consecutive one. CYCLES = 0 never expires.
module zeroriscy_trace_timeout #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'((CYCLES == 0) ? 0 : CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_hit;

  assign w_hit = (CYCLES != 0) && i_enable && !i_clear && (r_count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || !i_enable || w_hit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = w_hit;

endmodule

// File: rtl/zeroriscy_trace_unpacker.sv
// Receive-side trace unpacker: parses the compact retirement-trace byte stream
// and presents complete per-instruction / writeback records on a valid-ready port.
module zeroriscy_trace_unpacker
  import zeroriscy_trace_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic                      rec_is_wb,
  output logic [31:0]               rec_cycle,
  output logic [31:0]               rec_pc,
  output logic [31:0]               rec_instr,
  output logic                      rec_compressed,
  output logic                      rec_rd_en,
  output logic [REG_ADDR_WIDTH-1:0] rec_rd_addr,
  output logic [31:0]               rec_rd_value,
  output logic                      rec_mem_en,
  output logic [31:0]               rec_mem_addr,
  output logic                      err,
  output logic                      in_sync
);

  localparam logic [7:0] RDA_RSVD_MASK = 8'hFF << REG_ADDR_WIDTH;

  unpack_state_e r_state, w_state_next;
  logic [1:0]    r_idx, w_idx_next;

  logic r_is_wb, r_has_rd, r_has_mem, r_compressed;
  logic [31:0] r_acc, r_pc, r_instr, r_rd_value, r_mem_addr, r_sync_word;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;

  trace_rec_t                r_rec, w_rec_new;
  logic [REG_ADDR_WIDTH-1:0] r_rec_rd_addr;
  logic                      r_rec_valid, r_err, r_in_sync;

  logic        w_accept, w_final, w_load_rec, w_proto_err, w_expire;
  logic        w_sync_done, w_hdr_pkt, w_timer_en;
  logic [1:0]  w_instr_last_idx;
  logic [31:0] w_field_upd;

  assign w_instr_last_idx = r_compressed ? 2'd1 : 2'd3;

  // Is the byte at the head of the link the last byte of a record?
  always_comb begin
    w_final = 1'b0;
    case (r_state)
      ST_INSTR: w_final = (r_idx == w_instr_last_idx) && !r_has_rd && !r_has_mem;
      ST_RDV:   w_final = (r_idx == 2'd3) && !r_has_mem;
      ST_MEM:   w_final = (r_idx == 2'd3);
      default:  w_final = 1'b0;
    endcase
  end

  assign in_ready   = !(w_final && r_rec_valid && !rec_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_load_rec = w_accept && w_final;
  assign w_timer_en = (r_state != ST_HUNT) && (r_state != ST_HDR);

  always_comb begin
    w_field_upd = r_pc;
    case (r_state)
      ST_PC:    w_field_upd = put_byte(r_pc, r_idx, in_data);
      ST_INSTR: w_field_upd = put_byte(r_instr, r_idx, in_data);
      ST_RDV:   w_field_upd = put_byte(r_rd_value, r_idx, in_data);
      ST_MEM:   w_field_upd = put_byte(r_mem_addr, r_idx, in_data);
      ST_SYNC:  w_field_upd = put_byte(r_sync_word, r_idx, in_data);
      default:  w_field_upd = r_pc;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_proto_err  = 1'b0;
    w_sync_done  = 1'b0;
    w_hdr_pkt    = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_HUNT: begin
          if (in_data == SYNC_HDR) begin
            w_state_next = ST_SYNC;
            w_idx_next   = 2'd0;
          end
        end
        ST_HDR: begin
          if (in_data == SYNC_HDR) begin
            w_state_next = ST_SYNC;
            w_idx_next   = 2'd0;
          end else if ((in_data == WB_HDR) || instr_hdr_ok(in_data)) begin
            w_hdr_pkt    = 1'b1;
            w_state_next = ST_DELTA;
          end else if (in_data != IDLE) begin
            w_proto_err = 1'b1;
          end
        end
        ST_DELTA: begin
          w_state_next = r_is_wb ? ST_RDA : ST_PC;
          w_idx_next   = 2'd0;
        end
        ST_PC: begin
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_next = ST_INSTR;
        end
        ST_INSTR: begin
          if (r_idx == w_instr_last_idx) begin
            w_idx_next   = 2'd0;
            w_state_next = r_has_rd ? ST_RDA : (r_has_mem ? ST_MEM : ST_HDR);
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end
        ST_RDA: begin
          if ((in_data & RDA_RSVD_MASK) != 8'h00) begin
            w_proto_err = 1'b1;
          end else begin
            w_state_next = ST_RDV;
            w_idx_next   = 2'd0;
          end
        end
        ST_RDV: begin
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_next = r_has_mem ? ST_MEM : ST_HDR;
        end
        ST_MEM: begin
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_next = ST_HDR;
        end
        ST_SYNC: begin
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_sync_done  = 1'b1;
            w_state_next = ST_HDR;
          end
        end
        default: w_state_next = ST_HUNT;
      endcase
    end
    if (w_proto_err || w_expire) begin
      w_state_next = ST_HUNT;
      w_idx_next   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HUNT;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wb      <= 1'b0;
      r_has_rd     <= 1'b0;
      r_has_mem    <= 1'b0;
      r_compressed <= 1'b0;
      r_acc        <= '0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_rd_addr    <= '0;
      r_rd_value   <= '0;
      r_mem_addr   <= '0;
      r_sync_word  <= '0;
    end else if (w_accept) begin
      // Fields are cleared per packet so absent ones read back as zero.
      if (w_hdr_pkt) begin
        r_is_wb      <= (in_data == WB_HDR);
        r_has_rd     <= (in_data == WB_HDR) || in_data[FLAG_HAS_RD];
        r_has_mem    <= in_data[FLAG_HAS_MEM];
        r_compressed <= in_data[FLAG_COMPRESSED];
        r_pc         <= '0;
        r_instr      <= '0;
        r_rd_addr    <= '0;
        r_rd_value   <= '0;
        r_mem_addr   <= '0;
      end
      case (r_state)
        ST_DELTA: r_acc      <= r_acc + {24'h0, in_data};
        ST_PC:    r_pc       <= w_field_upd;
        ST_INSTR: r_instr    <= w_field_upd;
        ST_RDA:   r_rd_addr  <= in_data[REG_ADDR_WIDTH-1:0];
        ST_RDV:   r_rd_value <= w_field_upd;
        ST_MEM:   r_mem_addr <= w_field_upd;
        ST_SYNC: begin
          r_sync_word <= w_field_upd;
          if (w_sync_done) r_acc <= w_field_upd;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rec_new            = '0;
    w_rec_new.is_wb      = r_is_wb;
    w_rec_new.cycle      = r_acc;
    w_rec_new.pc         = r_pc;
    w_rec_new.instr      = (r_state == ST_INSTR) ? w_field_upd : r_instr;
    w_rec_new.compressed = r_compressed;
    w_rec_new.rd_en      = r_has_rd;
    w_rec_new.rd_value   = (r_state == ST_RDV) ? w_field_upd : r_rd_value;
    w_rec_new.mem_en     = r_has_mem;
    w_rec_new.mem_addr   = (r_state == ST_MEM) ? w_field_upd : r_mem_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rec         <= '0;
      r_rec_rd_addr <= '0;
      r_rec_valid   <= 1'b0;
    end else if (w_load_rec) begin
      r_rec         <= w_rec_new;
      r_rec_rd_addr <= r_rd_addr;
      r_rec_valid   <= 1'b1;
    end else if (rec_ready) begin
      r_rec_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_in_sync <= 1'b0;
    end else begin
      r_err <= w_proto_err || w_expire;
      if (w_proto_err || w_expire) begin
        r_in_sync <= 1'b0;
      end else if (w_sync_done) begin
        r_in_sync <= 1'b1;
      end
    end
  end

  zeroriscy_trace_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_enable(w_timer_en),
    .o_expire(w_expire)
  );

  assign rec_valid      = r_rec_valid;
  assign rec_is_wb      = r_rec.is_wb;
  assign rec_cycle      = r_rec.cycle;
  assign rec_pc         = r_rec.pc;
  assign rec_instr      = r_rec.instr;
  assign rec_compressed = r_rec.compressed;
  assign rec_rd_en      = r_rec.rd_en;
  assign rec_rd_addr    = r_rec_rd_addr;
  assign rec_rd_value   = r_rec.rd_value;
  assign rec_mem_en     = r_rec.mem_en;
  assign rec_mem_addr   = r_rec.mem_addr;
  assign err            = r_err;
  assign in_sync        = r_in_sync;

endmodule

// File: tb/tb_zeroriscy_trace_unpacker.sv
// Directed bench for zeroriscy_trace_unpacker: sync, instr/wb records,
// back-pressure, protocol errors and idle timeout with accumulator wrap.
module tb_zeroriscy_trace_unpacker;

  localparam int RAW = 5;
  localparam int TO  = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           rec_valid;
  logic           rec_ready;
  logic           rec_is_wb;
  logic [31:0]    rec_cycle;
  logic [31:0]    rec_pc;
  logic [31:0]    rec_instr;
  logic           rec_compressed;
  logic           rec_rd_en;
  logic [RAW-1:0] rec_rd_addr;
  logic [31:0]    rec_rd_value;
  logic           rec_mem_en;
  logic [31:0]    rec_mem_addr;
  logic           err;
  logic           in_sync;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  zeroriscy_trace_unpacker #(
    .REG_ADDR_WIDTH(RAW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_is_wb     (rec_is_wb),
    .rec_cycle     (rec_cycle),
    .rec_pc        (rec_pc),
    .rec_instr     (rec_instr),
    .rec_compressed(rec_compressed),
    .rec_rd_en     (rec_rd_en),
    .rec_rd_addr   (rec_rd_addr),
    .rec_rd_value  (rec_rd_value),
    .rec_mem_en    (rec_mem_en),
    .rec_mem_addr  (rec_mem_addr),
    .err           (err),
    .in_sync       (in_sync)
  );

  always @(negedge clk) if (!rst && err) err_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic [8*24-1:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_rec();
    rec_ready = 1'b1;
    @(posedge clk); #1;
    rec_ready = 1'b0;
    chk("pop_valid_low", {31'b0, rec_valid}, 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; rec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rec_valid", {31'b0, rec_valid}, 32'd0);
    chk("rst_err",       {31'b0, err},       32'd0);
    chk("rst_in_sync",   {31'b0, in_sync},   32'd0);
    chk("rst_rec_cycle", rec_cycle,          32'd0);
    chk("rst_rec_pc",    rec_pc,             32'd0);
    rst = 1'b0;

    // Junk then sync to 0x10
    send_pkt({8'h11, 8'h22, 8'hC0, 8'h10, 8'h00, 8'h00, 8'h00}, 7);
    idle_cycle();
    chk("sync_in_sync", {31'b0, in_sync},   32'd1);
    chk("sync_no_rec",  {31'b0, rec_valid}, 32'd0);
    chk("sync_no_err",  err_seen,           32'd0);

    // Full instr record with rd and mem, held by the sink
    rec_ready = 1'b0;
    send_pkt({8'h43, 8'h05, 8'h00, 8'h01, 8'h00, 8'h80, 8'h13, 8'h05, 8'hA0, 8'h00,
              8'h0A, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h80}, 19);
    chk("i1_valid",  {31'b0, rec_valid}, 32'd1);
    in_valid = 1'b0;
    chk("i1_is_wb",  {31'b0, rec_is_wb}, 32'd0);
    chk("i1_cycle",  rec_cycle,          32'h15);
    chk("i1_pc",     rec_pc,             32'h80000100);
    chk("i1_instr",  rec_instr,          32'h00A00513);
    chk("i1_comp",   {31'b0, rec_compressed}, 32'd0);
    chk("i1_rd_en",  {31'b0, rec_rd_en}, 32'd1);
    chk("i1_rd_addr", {27'b0, rec_rd_addr}, 32'd10);
    chk("i1_rd_val", rec_rd_value,       32'h2A);
    chk("i1_mem_en", {31'b0, rec_mem_en}, 32'd1);
    chk("i1_mem",    rec_mem_addr,       32'h80002000);
    pop_rec();

    // Compressed instr, no rd/mem
    send_pkt({8'h44, 8'h03, 8'h04, 8'h02, 8'h00, 8'h80, 8'h05, 8'h45}, 8);
    in_valid = 1'b0;
    chk("c_valid",  {31'b0, rec_valid},      32'd1);
    chk("c_cycle",  rec_cycle,               32'h18);
    chk("c_pc",     rec_pc,                  32'h80000204);
    chk("c_instr",  rec_instr,               32'h00004505);
    chk("c_comp",   {31'b0, rec_compressed}, 32'd1);
    chk("c_rd_en",  {31'b0, rec_rd_en},      32'd0);
    chk("c_mem_en", {31'b0, rec_mem_en},     32'd0);
    chk("c_rd_val", rec_rd_value,            32'd0);
    pop_rec();

    // Writeback-only record
    send_pkt({8'h80, 8'h02, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 7);
    in_valid = 1'b0;
    chk("wb_valid",   {31'b0, rec_valid}, 32'd1);
    chk("wb_is_wb",   {31'b0, rec_is_wb}, 32'd1);
    chk("wb_cycle",   rec_cycle,          32'h1A);
    chk("wb_pc",      rec_pc,             32'd0);
    chk("wb_rd_addr", {27'b0, rec_rd_addr}, 32'd5);
    chk("wb_rd_val",  rec_rd_value,       32'hDEADBEEF);
    chk("wb_mem_en",  {31'b0, rec_mem_en}, 32'd0);
    pop_rec();

    // Resync while locked, with an idle byte first
    send_pkt({8'h00, 8'hC0, 8'h00, 8'h01, 8'h00, 8'h00}, 6);
    idle_cycle();
    chk("resync_in_sync", {31'b0, in_sync}, 32'd1);
    chk("resync_no_err",  err_seen,         32'd0);

    // Back-pressure: second record's final byte waits for the first handshake
    send_pkt({8'h44, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00}, 8);
    chk("stA_valid", {31'b0, rec_valid}, 32'd1);
    chk("stA_cycle", rec_cycle,          32'h101);
    send_pkt({8'h44, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02}, 7);
    in_valid = 1'b1;
    in_data  = 8'h00;
    #1;
    chk("st_in_ready_low", {31'b0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("st_in_ready_still_low", {31'b0, in_ready}, 32'd0);
    chk("st_hold_pc",    rec_pc,    32'd0);
    chk("st_hold_instr", rec_instr, 32'h1);
    chk("st_hold_cycle", rec_cycle, 32'h101);
    rec_ready = 1'b1;
    #1;
    chk("st_in_ready_release", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stB_valid", {31'b0, rec_valid}, 32'd1);
    chk("stB_pc",    rec_pc,             32'h10);
    chk("stB_instr", rec_instr,          32'h2);
    chk("stB_cycle", rec_cycle,          32'h102);
    @(posedge clk); #1;
    chk("stB_drained", {31'b0, rec_valid}, 32'd0);

    // Bad header: reserved bit set
    send_byte(8'h48);
    chk("bad_hdr_err",     {31'b0, err},     32'd1);
    chk("bad_hdr_in_sync", {31'b0, in_sync}, 32'd0);
    send_pkt({8'h80, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 7);
    idle_cycle();
    chk("hunt_err_pulse", err_seen,           32'd1);
    chk("hunt_no_rec",    {31'b0, rec_valid}, 32'd0);
    chk("hunt_in_sync",   {31'b0, in_sync},   32'd0);

    // Reserved rd_addr bits
    send_pkt({8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 5);
    chk("rda_sync", {31'b0, in_sync}, 32'd1);
    send_pkt({8'h80, 8'h02, 8'h20}, 3);
    chk("rda_err", {31'b0, err}, 32'd1);
    idle_cycle();
    chk("rda_err_count", err_seen, 32'd2);

    // Partial packet then idle timeout
    send_pkt({8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h44, 8'h02, 8'h00}, 8);
    in_valid = 1'b0;
    k = 0;
    while (!err && k < 1200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("to_expiry_cycle", k,                32'd1024);
    chk("to_in_sync",      {31'b0, in_sync}, 32'd0);
    @(posedge clk); #1;
    chk("to_err_one_cycle", {31'b0, err},    32'd0);
    chk("to_err_count",     err_seen,        32'd3);

    // Accumulator wrap after resync
    send_pkt({8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h80, 8'h02, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00}, 12);
    in_valid = 1'b0;
    chk("wrap_valid",   {31'b0, rec_valid},   32'd1);
    chk("wrap_cycle",   rec_cycle,            32'h00000001);
    chk("wrap_is_wb",   {31'b0, rec_is_wb},   32'd1);
    chk("wrap_rd_addr", {27'b0, rec_rd_addr}, 32'd3);
    chk("wrap_rd_val",  rec_rd_value,         32'd1);
    @(posedge clk); #1;
    chk("wrap_drained", {31'b0, rec_valid},   32'd0);
    chk("final_err_count", err_seen,          32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
